// File: rtl/maddsub_iter_if.sv
// Operand/result bundle between the execute stage and the iterative multiply-add unit.
interface maddsub_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] C;
  logic               sign;
  logic               fused;
  logic               subtract;
  logic               start;
  logic               busy;
  logic               done;
  logic [2*WIDTH:0]   D;

  modport master (
    output A, B, C, sign, fused, subtract, start,
    input  busy, done, D
  );

  modport slave (
    input  A, B, C, sign, fused, subtract, start,
    output busy, done, D
  );
endinterface

// File: rtl/maddsub_iter.sv
// Iterative shift-add multiply / multiply-add / multiply-subtract for the HI/LO path.
// Retires STEP multiplier bits per cycle, then sign-fixes and optionally accumulates.
module maddsub_iter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STEP         = 4,
  parameter int unsigned ACC_INTERNAL = 0
) (
  input  logic         clock,
  input  logic         reset,
  maddsub_iter_if.slave bus
);
  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned N     = WIDTH / STEP;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, MUL, FIX, ADD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [W2-1:0]    c_reg;
  logic             sign_q;
  logic             fused_q;
  logic             sub_q;
  logic             psign_q;
  logic [W2:0]      d_q;
  logic             done_q;
  logic             busy_c;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [W2-1:0]    partial;
  logic [W2-1:0]    p_fix;
  logic [W2:0]      ce;
  logic [W2:0]      pe;
  logic             last_mul;

  // Operand magnitudes, product digit, sign fix-up and extended accumulate operands
  always_comb begin
    a_mag    = (bus.sign && bus.A[WIDTH-1]) ? WIDTH'(-bus.A) : bus.A;
    b_mag    = (bus.sign && bus.B[WIDTH-1]) ? WIDTH'(-bus.B) : bus.B;
    partial  = a_sh * W2'(b_sh[STEP-1:0]);
    last_mul = (count == CNT_W'(N - 1));
    p_fix    = (sign_q && psign_q) ? W2'(-acc) : acc;
    ce       = {sign_q & c_reg[W2-1], c_reg};
    pe       = {sign_q & acc[W2-1], acc};
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: start restarts from any state
  always_comb begin
    state_nxt = state;
    if (bus.start) begin
      state_nxt = MUL;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        MUL:     if (last_mul) state_nxt = FIX;
        FIX:     state_nxt = fused_q ? ADD : IDLE;
        ADD:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy_c = 1'b0;
    if (state != IDLE) busy_c = 1'b1;
  end

  // Datapath: capture on start, shift-add in MUL, finalise in FIX/ADD
  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      c_reg   <= '0;
      sign_q  <= 1'b0;
      fused_q <= 1'b0;
      sub_q   <= 1'b0;
      psign_q <= 1'b0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        sign_q  <= bus.sign;
        fused_q <= bus.fused;
        sub_q   <= bus.subtract;
        psign_q <= bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        a_sh    <= W2'(a_mag);
        b_sh    <= b_mag;
        acc     <= '0;
        count   <= '0;
        c_reg   <= (ACC_INTERNAL != 0) ? d_q[W2-1:0] : bus.C;
      end else begin
        unique case (state)
          MUL: begin
            acc   <= acc + partial;
            a_sh  <= a_sh << STEP;
            b_sh  <= b_sh >> STEP;
            count <= count + CNT_W'(1);
          end
          FIX: begin
            acc <= p_fix;
            if (!fused_q) begin
              d_q    <= {sign_q & p_fix[W2-1], p_fix};
              done_q <= 1'b1;
            end
          end
          ADD: begin
            d_q    <= sub_q ? (ce - pe) : (ce + pe);
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.D    = d_q;
endmodule

// File: tb/tb_maddsub_iter.sv
// Bench for maddsub_iter: five instances (STEP 4/4-chained/1/2/8) share stimulus and are
// checked against an exact-arithmetic model with cycle-exact done timing.
module tb_maddsub_iter;
  localparam int unsigned W    = 32;
  localparam int unsigned NDUT = 5;
  localparam int          OBS  = 40;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] c;
  logic sg, fu, su, start;

  logic [NDUT-1:0] busy_v, done_v;
  logic [2*W:0]    d_v [NDUT];

  int vectors    = 0;
  int miscompares = 0;

  logic [2*W:0] exp_d [NDUT];
  logic [2*W:0] acc_prev;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned ST = (g == 2) ? 1 : (g == 3) ? 2 : (g == 4) ? 8 : 4;
    localparam int unsigned AI = (g == 1) ? 1 : 0;
    maddsub_iter_if #(.WIDTH(W)) bus ();
    assign bus.A        = a;
    assign bus.B        = b;
    assign bus.C        = c;
    assign bus.sign     = sg;
    assign bus.fused    = fu;
    assign bus.subtract = su;
    assign bus.start    = start;
    maddsub_iter #(.WIDTH(W), .STEP(ST), .ACC_INTERNAL(AI)) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
    );
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign d_v[g]    = bus.D;
  end

  function automatic int step_of(input int g);
    return (g == 2) ? 1 : (g == 3) ? 2 : (g == 4) ? 8 : 4;
  endfunction

  function automatic int lat_of(input int g, input logic f);
    return W / step_of(g) + 1 + (f ? 1 : 0);
  endfunction

  // Exact integer arithmetic, reduced to the 2W+1-bit result register
  function automatic logic [2*W:0] model(input logic [W-1:0] ma, mb, input logic [2*W-1:0] mc,
                                         input logic ms, mf, msub);
    logic signed [127:0] av, bv, cv, r;
    av = ms ? {{96{ma[W-1]}}, ma} : {96'd0, ma};
    bv = ms ? {{96{mb[W-1]}}, mb} : {96'd0, mb};
    cv = ms ? {{64{mc[2*W-1]}}, mc} : {64'd0, mc};
    r  = av * bv;
    if (mf) r = msub ? (cv - r) : (cv + r);
    return r[2*W:0];
  endfunction

  task automatic chk(input string nm, input logic [2*W:0] got, input logic [2*W:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  // Called just after the start edge; watches OBS edges for each instance's single done
  task automatic observe(input logic f, input string tag);
    int first [NDUT];
    int cnt   [NDUT];
    logic [2*W:0] got [NDUT];
    logic [NDUT-1:0] busy_end;
    for (int g = 0; g < NDUT; g++) begin
      first[g] = -1; cnt[g] = 0; got[g] = '0; busy_end[g] = 1'b1;
    end
    for (int k = 1; k <= OBS; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NDUT; g++) begin
        if (done_v[g]) begin
          cnt[g]++;
          if (first[g] < 0) first[g] = k;
          got[g] = d_v[g];
        end
        if (k == lat_of(g, f)) busy_end[g] = busy_v[g];
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("%s dut%0d done_cycle", tag, g), 65'(first[g]), 65'(lat_of(g, f)));
      chk($sformatf("%s dut%0d done_count", tag, g), 65'(cnt[g]), 65'd1);
      chk($sformatf("%s dut%0d busy_after", tag, g), 65'(busy_end[g]), 65'd0);
      chk($sformatf("%s dut%0d D", tag, g), got[g], exp_d[g]);
    end
    acc_prev = exp_d[1];
  endtask

  task automatic pulse_start(input logic [W-1:0] ta, tb_, input logic [2*W-1:0] tc,
                             input logic ts, tf, tsub);
    @(negedge clk);
    a = ta; b = tb_; c = tc; sg = ts; fu = tf; su = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] ta, tb_, input logic [2*W-1:0] tc,
                        input logic ts, tf, tsub, input string tag);
    for (int g = 0; g < NDUT; g++)
      exp_d[g] = model(ta, tb_, (g == 1) ? acc_prev[2*W-1:0] : tc, ts, tf, tsub);
    pulse_start(ta, tb_, tc, ts, tf, tsub);
    chk({tag, " busy_at_start"}, 65'(busy_v), 65'({NDUT{1'b1}}));
    observe(tf, tag);
  endtask

  function automatic logic [W-1:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [W-1:0]   a, b;
    logic [2*W-1:0] c;
    logic           sg, fu, su;
    logic [2*W:0]   expd;
    logic [2*W:0]   exp_i;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] rc;
    logic orx;

    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 1'b0, 1'b0, 1'b0,
               65'h0_FFFFFFFE_00000001, 65'h0_FFFFFFFE_00000001};
    tbl[1] = '{32'hFFFF_FFFF, 32'h8000_0000, 64'h0, 1'b1, 1'b0, 1'b0,
               65'h0_00000000_80000000, 65'h0_00000000_80000000};
    tbl[2] = '{32'h8000_0000, 32'h8000_0000, 64'h0, 1'b1, 1'b0, 1'b0,
               65'h0_40000000_00000000, 65'h0_40000000_00000000};
    tbl[3] = '{32'h1, 32'h1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b1, 1'b0,
               65'h1_00000000_00000000, 65'h0_40000000_00000001};
    tbl[4] = '{32'h0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0,
               65'h0, 65'h0};
    tbl[5] = '{32'h3, 32'h5, 64'h0, 1'b1, 1'b1, 1'b1,
               65'h1_FFFFFFFF_FFFFFFF1, 65'h1_FFFFFFFF_FFFFFFF1};
    tbl[6] = '{32'h1, 32'h1, 64'h0, 1'b1, 1'b1, 1'b0,
               65'h0_00000000_00000001, 65'h1_FFFFFFFF_FFFFFFF2};
    tbl[7] = '{32'h1, 32'h1, 64'h0, 1'b0, 1'b1, 1'b1,
               65'h1_FFFFFFFF_FFFFFFFF, 65'h0_FFFFFFFF_FFFFFFF1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0; sg = 1'b0; fu = 1'b0; su = 1'b0;
    acc_prev = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("reset dut%0d busy", g), 65'(busy_v[g]), 65'd0);
      chk($sformatf("reset dut%0d done", g), 65'(done_v[g]), 65'd0);
      chk($sformatf("reset dut%0d D", g), d_v[g], 65'd0);
    end
    @(negedge clk); rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sg, tbl[i].fu, tbl[i].su,
             $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d const D", i), d_v[0], tbl[i].expd);
      chk($sformatf("tbl%0d const D_chain", i), d_v[1], tbl[i].exp_i);
    end

    // Restart mid-operation: first operation must never complete
    pulse_start(32'd2, 32'd2, 64'd0, 1'b0, 1'b0, 1'b0);
    orx = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      orx = orx | (|done_v);
    end
    for (int g = 0; g < NDUT; g++) exp_d[g] = 65'd42;
    pulse_start(32'd7, 32'd6, 64'd0, 1'b0, 1'b0, 1'b0);
    orx = orx | (|done_v);
    chk("restart no_early_done", 65'(orx), 65'd0);
    observe(1'b0, "restart");

    // Reset at cycle 5 of a fused operation, with start asserted alongside
    pulse_start(32'd5, 32'hFFFF_FFFD, 64'd100, 1'b1, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("midreset dut%0d busy", g), 65'(busy_v[g]), 65'd0);
      chk($sformatf("midreset dut%0d done", g), 65'(done_v[g]), 65'd0);
      chk($sformatf("midreset dut%0d D", g), d_v[g], 65'd0);
    end
    orx = 1'b0;
    repeat (OBS) begin
      @(posedge clk); #1;
      orx = orx | (|done_v) | (|busy_v);
    end
    chk("midreset stays_idle", 65'(orx), 65'd0);
    acc_prev = '0;

    // Random sweep over operands and all modes
    for (int i = 0; i < 1100; i++) begin
      ra = pick32();
      rb = pick32();
      case ($urandom_range(0, 3))
        0:       rc = 64'h0;
        1:       rc = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       rc = 64'h8000_0000_0000_0000;
        default: rc = {32'($urandom), 32'($urandom)};
      endcase
      run_op(ra, rb, rc, 1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
